// File: rtl/button_pulser_if.sv
// rtl/button_pulser_if.sv - button-side signals of the pulser: raw button in, strobe and level out
// master drives the raw button; slave is the pulser itself.
interface button_pulser_if;
   logic Bin;
   logic Dout;
   logic pressed;

   modport master (
      output Bin,
      input  Dout,
      input  pressed
   );

   modport slave (
      input  Bin,
      output Dout,
      output pressed
   );
endinterface

// File: rtl/button_pulser.sv
// rtl/button_pulser.sv - synchronise, debounce and auto-repeat a pushbutton into one-cycle strobes
// One shared timer serves press debounce, release debounce, repeat delay and repeat period.
module button_pulser #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000,
   parameter int unsigned CNT_W           = 25
) (
   input  logic             Clkin,
   input  logic             clear,
   button_pulser_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_HELD,
      ST_REPEAT,
      ST_RELEASE_WAIT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REPEAT_PERIOD - 1);

   logic             s1_q;
   logic             s_q;
   state_t           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             dout_q,    dout_d;
   logic             pressed_q, pressed_d;

   always_ff @(posedge Clkin) begin
      if (clear) begin
         s1_q      <= 1'b0;
         s_q       <= 1'b0;
         state_q   <= ST_IDLE;
         cnt_q     <= CNT_ZERO;
         dout_q    <= 1'b0;
         pressed_q <= 1'b0;
      end else begin
         s1_q      <= bus.Bin;
         s_q       <= s1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
         pressed_q <= pressed_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dout_d    = 1'b0;
      pressed_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s_q) begin
               state_d = ST_PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end
         end

         ST_PRESS_WAIT: begin
            if (!s_q) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_HELD;
               dout_d  = 1'b1;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_HELD: begin
            if (!s_q) begin
               state_d = ST_RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end else if (REPEAT_EN) begin
               if (cnt_q == DELAY_LAST) begin
                  state_d = ST_REPEAT;
                  dout_d  = 1'b1;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               cnt_d = CNT_ZERO;
            end
         end

         ST_REPEAT: begin
            if (!s_q) begin
               state_d = ST_RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end else if (cnt_q == PER_LAST) begin
               dout_d = 1'b1;
               cnt_d  = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_RELEASE_WAIT: begin
            // A short release is a glitch: return to HELD and restart the repeat delay.
            if (s_q) begin
               state_d = ST_HELD;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      pressed_d = (state_d == ST_HELD) || (state_d == ST_REPEAT) ||
                  (state_d == ST_RELEASE_WAIT);
   end

   assign bus.Dout    = dout_q;
   assign bus.pressed = pressed_q;

endmodule

// File: tb/tb_button_pulser.sv
// tb/tb_button_pulser.sv - directed per-edge vectors for two pulsers (repeat on / repeat off)
// Record e holds the inputs seen at edge e and the outputs expected just after it.
module tb_button_pulser;

   typedef struct {
      logic bin;
      logic clr;
      logic d0;
      logic p0;
      logic d1;
      logic p1;
      int   tag;
      int   edge_n;
   } vec_t;

   logic Clkin = 1'b0;
   logic clear;
   int   checks = 0;
   int   errors = 0;
   vec_t vec[$];

   always #5 Clkin = ~Clkin;

   button_pulser_if bif0 ();
   button_pulser_if bif1 ();

   button_pulser #(
      .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(4)
   ) dut0 (
      .Clkin(Clkin), .clear(clear), .bus(bif0.slave)
   );

   button_pulser #(
      .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(4)
   ) dut1 (
      .Clkin(Clkin), .clear(clear), .bus(bif1.slave)
   );

   function automatic void push(input logic bin, input logic clr, input logic d0,
                                input logic p0, input logic d1, input logic p1,
                                input int tag, input int edge_n);
      vec_t v;
      v.bin = bin; v.clr = clr; v.d0 = d0; v.p0 = p0; v.d1 = d1; v.p1 = p1;
      v.tag = tag; v.edge_n = edge_n;
      vec.push_back(v);
   endfunction

   function automatic void push_clear(input int tag);
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag, -2);
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag, -1);
   endfunction

   task automatic check_bit(input string name, input int tag, input int e,
                            input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s scen=%0d edge=%0d got=%b expected=%b", name, tag, e, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int strobes3;
      int n_hit;
      int extra;

      // 1: clean press and release
      push_clear(1);
      for (int e = 0; e < 16; e++)
         push(e <= 7, 1'b0, e == 5, e >= 5 && e <= 12, e == 5, e >= 5 && e <= 12, 1, e);
      // 2: bounce reject, then a fresh press released just before its first repeat would fire
      push_clear(2);
      for (int e = 0; e < 30; e++)
         push((e <= 2) || (e >= 8 && e <= 20), 1'b0, e == 13, e >= 13 && e <= 25,
              e == 13, e >= 13 && e <= 25, 2, e);
      // 3: auto-repeat on dut0, single strobe on dut1
      push_clear(3);
      for (int e = 0; e < 40; e++)
         push(e <= 30, 1'b0, e == 5 || (e >= 15 && e <= 30 && (e - 15) % 3 == 0),
              e >= 5 && e <= 35, e == 5, e >= 5 && e <= 35, 3, e);
      // 4: two-edge release glitch while held
      push_clear(4);
      for (int e = 0; e < 25; e++)
         push(!(e == 7 || e == 8), 1'b0, e == 5 || e == 21 || e == 24, e >= 5,
              e == 5, e >= 5, 4, e);
      // 5: clear on the edge a repeat strobe is due
      push_clear(5);
      for (int e = 0; e < 30; e++)
         push(1'b1, e == 18, e == 5 || e == 15 || e == 24,
              (e >= 5 && e <= 17) || e >= 24, e == 5 || e == 24,
              (e >= 5 && e <= 17) || e >= 24, 5, e);

      strobes3 = 0;
      foreach (vec[i]) begin
         bif0.Bin = vec[i].bin;
         bif1.Bin = vec[i].bin;
         clear    = vec[i].clr;
         @(posedge Clkin);
         #1;
         check_bit("dout_rep",    vec[i].tag, vec[i].edge_n, bif0.Dout,    vec[i].d0);
         check_bit("pressed_rep", vec[i].tag, vec[i].edge_n, bif0.pressed, vec[i].p0);
         check_bit("dout_one",    vec[i].tag, vec[i].edge_n, bif1.Dout,    vec[i].d1);
         check_bit("pressed_one", vec[i].tag, vec[i].edge_n, bif1.pressed, vec[i].p1);
         if (vec[i].tag == 3 && bif0.Dout === 1'b1) strobes3++;
      end
      check_int("repeat_strobe_count", strobes3, 7);

      // Clear held for several edges with the button down: nothing may come out.
      bif0.Bin = 1'b1;
      bif1.Bin = 1'b1;
      clear    = 1'b1;
      extra    = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge Clkin);
         #1;
         if (bif0.Dout !== 1'b0 || bif0.pressed !== 1'b0) extra++;
      end
      check_int("held_clear_quiet", extra, 0);

      // Held button after clear drops is a fresh press, strobed 6 edges after the last clear edge.
      clear = 1'b0;
      n_hit = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge Clkin);
         #1;
         if (bif0.Dout === 1'b1) begin
            n_hit = n;
            break;
         end
      end
      check_int("fresh_press_latency", n_hit, 6);
      check_bit("fresh_press_pressed", 6, n_hit, bif0.pressed, 1'b1);

      // Release: pressed falls 5 edges after Bin first samples low, with no strobe meanwhile.
      bif0.Bin = 1'b0;
      bif1.Bin = 1'b0;
      n_hit    = -1;
      extra    = 0;
      for (int m = 0; m < 20; m++) begin
         @(posedge Clkin);
         #1;
         if (bif0.Dout === 1'b1) extra++;
         if (bif0.pressed === 1'b0) begin
            n_hit = m;
            break;
         end
      end
      check_int("release_latency", n_hit, 5);
      check_int("release_no_strobe", extra, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
